// File: rtl/regfile_scoreboard.sv
// Register file with NREAD combinational read ports, one write port and a tagged busy scoreboard.
// Latency: reads are combinational (0 cycles, optional same-cycle write bypass); state updates on posedge.
// Backpressure: none; issue always accepted (overwrites the tag), writeback always accepted.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int TAGW   = 3,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic [TAGW-1:0]         wr_tag,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic [TAGW-1:0]         iss_tag,
    input  logic                    flush,
    input  logic [AW-1:0]           dest_read,
    output logic [XLEN-1:0]         dest_value,
    output logic [AW:0]             busy_count
);

    logic [XLEN-1:0] regs [NREGS];
    logic [TAGW-1:0] tags [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      count_nxt;

    // A write to register 0 is discarded; it is the only source of new data.
    logic wr_live;
    assign wr_live = wr_en && (wr_addr != '0);

    // Forwarding is suppressed while in reset so every read port shows 0.
    logic byp_en;
    assign byp_en = (BYPASS != 0) && reset && wr_live;

    // Next busy vector: tag-matched writeback clears, then issue sets (issue wins), flush clears all.
    always_comb begin
        busy_nxt = busy;
        if (wr_live && (tags[wr_addr] == wr_tag)) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (iss_en && (iss_addr != '0)) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector, registered alongside it.
    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[i]};
        end
    end

    // Data storage: every non-zero write lands, whatever the scoreboard says.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard state: busy bits, producer tags and the busy population count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
            for (int i = 0; i < NREGS; i++) begin
                tags[i] <= '0;
            end
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
            if (!flush && iss_en && (iss_addr != '0)) begin
                tags[iss_addr] <= iss_tag;
            end
        end
    end

    // Read ports: register 0 holds zero and is never busy, so no special case is needed here.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;
        assign addr = rd_addr[k*AW +: AW];
        assign hit  = byp_en && (wr_addr == addr);
        assign rd_data[k*XLEN +: XLEN] = hit ? wr_data : regs[addr];
        assign rd_busy[k] = hit ? (busy[addr] && (tags[addr] != wr_tag)) : busy[addr];
    end

    assign dest_value = (byp_en && (wr_addr == dest_read)) ? wr_data : regs[dest_read];

endmodule
